if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch front end: generates sequential PCs from a configurable reset vector, issues requests to a one-cycle-latency instruction memory, and buffers {pc, inst} pairs in a DEPTH-entry queue. The queue drives decode through a valid/ready handshake. It sits between instruction memory and the decode stage. Unlike a free-running PC counter, it adds:

- back-pressure through credit-based request throttling,
- branch/exception redirect with wrong-path flush,
- a configurable reset PC and configurable widths.

## Interface
Parameters:
- XLEN, 64, PC / address width
- ILEN, 32, instruction width
- RESET_PC, 64'h0, PC fetched first after reset (low 2 bits must be 0)
- DEPTH, 4, queue entries; power of two, >= 2

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  synchronous, active-low reset
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] ignored (treated as 0)
- inst_addr  out  XLEN  memory request address (= pc)
- inst_ena  out  1  memory request strobe
- inst_rdata  in  ILEN  memory data, valid the cycle after inst_ena was high
- out_valid  out  1  queue head valid to decode
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head entry
- out_inst  out  ILEN  instruction of head entry
- count  out  $clog2(DEPTH)+1  occupied queue entries

## Operation
- Registers:
  - `pc`
  - `rsp_valid`, `rsp_pc` (the request issued last cycle)
  - queue storage, rd/wr pointers, `count`
- Pop: `pop = out_valid & out_ready`.
- Issue condition: `inst_ena = rst & ~redirect_valid & (count + rsp_valid - pop < DEPTH)`.
  - Credits cover the in-flight response, so the queue never overflows.
  - With DEPTH >= 2 and out_ready held high, throughput is 1 instruction per cycle.
- When inst_ena is high: `pc <= pc + 4` (wraps modulo 2^XLEN), `rsp_valid <= 1`, `rsp_pc <= pc`. Otherwise `rsp_valid <= 0` and `pc` holds.
- Push: `push = rsp_valid & ~redirect_valid` writes {rsp_pc, inst_rdata} at wr_ptr.
- Simultaneous push and pop with count=DEPTH cannot occur by credit rule.
- With count=0, a push is not visible the same cycle; there is no bypass.
- `count` updates by +push −pop. The queue pointers wrap at DEPTH.
- `out_valid = (count != 0) & ~redirect_valid`. `out_pc`/`out_inst` come from the head entry.
- Redirect (takes priority over everything), in the cycle redirect_valid is high:
  - inst_ena=0.
  - The arriving response is discarded.
  - The queue is emptied (count, ptrs <= 0).
  - `pc <= {redirect_pc[XLEN-1:2], 2'b00}`.
  - `rsp_valid <= 0`.
  - The first request at the new PC issues the following cycle, if redirect_valid has dropped.
- Back-to-back redirects: the last one wins. No fetch is issued while redirect_valid is held.
- Stall is expressed only through out_ready. The queue holds its contents and PC indefinitely.

## Timing
- Reset (rst=0 at posedge): `pc=RESET_PC`, `rsp_valid=0`, `count=0`, ptrs=0.
  - While rst=0: inst_ena=0, out_valid=0, `inst_addr=pc`.
- Fetch latency: inst_ena at cycle t → inst_rdata sampled at t+1 → out_valid at t+2 (if queue empty).
- After rst rises: first inst_ena in the same cycle (addr RESET_PC); first out_valid 2 cycles later.
- Redirect at cycle r: inst_ena with addr=redirect_pc at r+1; out_valid for it at r+3.
- Reset mid-operation: all in-flight and queued entries are lost. Behaviour is identical to power-on reset.

## Structure
- Package `if_pkg`:
  - ILEN constant.
  - `fetch_entry_t` = packed struct {pc[XLEN], inst[ILEN]}.
  - Default RESET_PC localparam.
- Sub-module `if_fifo`:
  - Synchronous FIFO, DEPTH entries of fetch_entry_t.
  - Has a synchronous flush input.
  - Exports count.
- The top level holds the PC, response register and credit logic.

## Test plan
- Reset release, RESET_PC=64'h8000_0000, out_ready=1 → inst_addr sequence 8000_0000, …_0004, …_0008 on consecutive cycles; out_pc the same sequence starting 2 cycles later; 1 instr/cycle sustained.
- out_ready=0 from reset, DEPTH=4 → exactly 4 requests issued, count saturates at 4, inst_ena stays 0.
  - Then raise out_ready → entries out in order, fetch resumes at RESET_PC+16, no loss or duplication.
- Redirect to 64'h1000 while queue holds 3 entries and a response is in flight → count=0 the next cycle; the in-flight instruction never appears; next out_pc=64'h1000; redirect_pc=64'h1003 also yields 64'h1000.
- Back-to-back redirects 64'h200 then 64'h300, plus redirect with out_ready=1 → only 64'h300 fetched; out_valid low during both redirect cycles; no pop occurs.
- PC wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC → next fetch addresses …FFFC, 64'h0, 64'h4.
- Reset asserted mid-stream with count=3 → next cycle count=0, out_valid=0, inst_ena=0; restart from RESET_PC after release.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
// fetch_entry_t is the default payload carried by the fetch queue.
package if_pkg;

  localparam int IF_XLEN = 64;
  localparam int IF_ILEN = 32;
  localparam logic [IF_XLEN-1:0] IF_RESET_PC = 64'h0;

  typedef struct packed {
    logic [IF_XLEN-1:0] pc;
    logic [IF_ILEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous DEPTH-entry FIFO with a single-cycle flush and an occupancy count.
// The caller guarantees no push when full and no pop when empty.
module if_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Flush discards everything, including a push arriving in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, one-cycle memory
// requests, credit-throttled issue and a decode-facing queue with redirect flush.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int               XLEN     = IF_XLEN,
  parameter int               ILEN     = IF_ILEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(IF_RESET_PC),
  parameter int               DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic [XLEN-1:0]        inst_addr,
  output logic                   inst_ena,
  input  logic [ILEN-1:0]        inst_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [ILEN-1:0]        out_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            push, pop, credit_ok;
  logic [CW:0]     occupancy;
  entry_t          push_entry, head;

  assign out_valid = rst & ~redirect_valid & (count != '0);
  assign pop       = out_valid & out_ready;

  // The response already in flight holds a credit, so issue only while
  // queued + in-flight - leaving entries stays below DEPTH.
  assign occupancy = (CW+1)'(count) + (CW+1)'(rsp_valid_q) - (CW+1)'(pop);
  assign credit_ok = occupancy < (CW+1)'(DEPTH);
  assign inst_ena  = rst & ~redirect_valid & credit_ok;
  assign inst_addr = pc_q;

  always_comb begin
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    rsp_valid_d = 1'b0;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~XLEN'(3);
    end else if (inst_ena) begin
      pc_d        = pc_q + XLEN'(4);
      rsp_pc_d    = pc_q;
      rsp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      rsp_pc_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign push       = rsp_valid_q & ~redirect_valid;
  assign push_entry = {rsp_pc_q, inst_rdata};

  if_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head),
    .count     (count)
  );

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with RESET_PC=64'h8000_0000, DEPTH=4 and
// a one-cycle memory model whose data is a fixed function of the address.
module tb_if_fetch_queue;

  localparam logic [63:0] R = 64'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] inst_addr;
  logic        inst_ena;
  logic [31:0] inst_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int testsRun = 0;
  int testsFailed = 0;
  int nReq;

  if_fetch_queue #(
    .XLEN     (64),
    .ILEN     (32),
    .RESET_PC (R),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_addr      (inst_addr),
    .inst_ena       (inst_ena),
    .inst_rdata     (inst_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    return a[31:0] ^ 32'hA5A5_0000;
  endfunction

  // Memory answers one cycle after a request; junk otherwise.
  always @(posedge clk) begin
    if (inst_ena) inst_rdata <= memWord(inst_addr);
    else          inst_rdata <= 32'hDEAD_BEEF;
  end

  task automatic applyStimulus(input logic r, input logic rv,
                               input logic [63:0] rpc, input logic ordy);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    #1;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic doReset;
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    nextCycle;
  endtask

  initial begin
    inst_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    nextCycle;
    nextCycle;

    // Reset state
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("rst_ena", 64'(inst_ena), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_addr", inst_addr, R);

    // Streaming from reset at one instruction per cycle
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
      checkOutput("t1_ena", 64'(inst_ena), 64'd1);
      checkOutput("t1_addr", inst_addr, R + 64'(4 * k));
      if (k >= 2) begin
        checkOutput("t1_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_pc", out_pc, R + 64'(4 * (k - 2)));
        checkOutput("t1_inst", 64'(out_inst), 64'(memWord(R + 64'(4 * (k - 2)))));
        checkOutput("t1_count", 64'(count), 64'd1);
      end else begin
        checkOutput("t1_valid_lo", 64'(out_valid), 64'd0);
      end
      nextCycle;
    end

    // Back-pressure: credits stop issue after exactly DEPTH requests
    doReset;
    nReq = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
      if (inst_ena) nReq++;
      nextCycle;
    end
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t2_reqs", 64'(nReq), 64'd4);
    checkOutput("t2_count", 64'(count), 64'd4);
    checkOutput("t2_ena", 64'(inst_ena), 64'd0);
    checkOutput("t2_head", out_pc, R);
    checkOutput("t2_addr", inst_addr, R + 64'd16);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
      checkOutput("t2_drain_valid", 64'(out_valid), 64'd1);
      checkOutput("t2_drain_pc", out_pc, R + 64'(4 * j));
      checkOutput("t2_drain_inst", 64'(out_inst), 64'(memWord(R + 64'(4 * j))));
      if (j == 0) begin
        checkOutput("t2_resume_ena", 64'(inst_ena), 64'd1);
        checkOutput("t2_resume_addr", inst_addr, R + 64'd16);
      end
      if (j == 1) checkOutput("t2_count_after_pop", 64'(count), 64'd3);
      nextCycle;
    end

    // Redirect with three queued entries and a response in flight
    doReset;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
      nextCycle;
    end
    applyStimulus(1'b1, 1'b1, 64'h1000, 1'b0);
    checkOutput("t3_pre_count", 64'(count), 64'd3);
    checkOutput("t3_redir_valid", 64'(out_valid), 64'd0);
    checkOutput("t3_redir_ena", 64'(inst_ena), 64'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t3_flush_count", 64'(count), 64'd0);
    checkOutput("t3_new_ena", 64'(inst_ena), 64'd1);
    checkOutput("t3_new_addr", inst_addr, 64'h1000);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t3_addr2", inst_addr, 64'h1004);
    checkOutput("t3_no_bypass", 64'(out_valid), 64'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t3_out_valid", 64'(out_valid), 64'd1);
    checkOutput("t3_out_pc", out_pc, 64'h1000);
    checkOutput("t3_out_inst", 64'(out_inst), 64'(memWord(64'h1000)));
    applyStimulus(1'b1, 1'b1, 64'h1003, 1'b0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t3_align_addr", inst_addr, 64'h1000);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t3_align_pc", out_pc, 64'h1000);

    // Back-to-back redirects while decode is ready
    doReset;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
      nextCycle;
    end
    applyStimulus(1'b1, 1'b1, 64'h200, 1'b1);
    checkOutput("t4_r1_valid", 64'(out_valid), 64'd0);
    checkOutput("t4_r1_ena", 64'(inst_ena), 64'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b1, 64'h300, 1'b1);
    checkOutput("t4_r2_valid", 64'(out_valid), 64'd0);
    checkOutput("t4_r2_ena", 64'(inst_ena), 64'd0);
    checkOutput("t4_r2_count", 64'(count), 64'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_addr", inst_addr, 64'h300);
    checkOutput("t4_ena", 64'(inst_ena), 64'd1);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_addr2", inst_addr, 64'h304);
    checkOutput("t4_empty", 64'(out_valid), 64'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_out_valid", 64'(out_valid), 64'd1);
    checkOutput("t4_out_pc", out_pc, 64'h300);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t4_out_pc2", out_pc, 64'h304);

    // PC wraps modulo 2^64
    applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t5_addr0", inst_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t5_addr1", inst_addr, 64'h0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t5_addr2", inst_addr, 64'h4);
    checkOutput("t5_out_pc0", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t5_out_pc1", out_pc, 64'h0);
    checkOutput("t5_out_inst1", 64'(out_inst), 64'(memWord(64'h0)));

    // Reset mid-stream with three queued entries
    doReset;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
      nextCycle;
    end
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("t6_pre_count", 64'(count), 64'd3);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t6_rst_ena", 64'(inst_ena), 64'd0);
    checkOutput("t6_rst_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_addr", inst_addr, R + 64'd16);
    nextCycle;
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("t6_count", 64'(count), 64'd0);
    checkOutput("t6_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_ena", 64'(inst_ena), 64'd0);
    checkOutput("t6_addr", inst_addr, R);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t6_restart_ena", 64'(inst_ena), 64'd1);
    checkOutput("t6_restart_addr", inst_addr, R);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t6_restart_empty", 64'(out_valid), 64'd0);
    nextCycle;
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("t6_restart_valid", 64'(out_valid), 64'd1);
    checkOutput("t6_restart_pc", out_pc, R);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
